regfile_writeback_queue: RTL and testbench
==========================================

Name: regfile_writeback_queue

Overview:
- Writer-side front end for the 32x32 three-read-port register file.
- Accepts register write requests from the execute/memory stages over a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one write per clock onto the register file write port (RW, PW, LE).
- Provides per-read-port forwarding of still-queued data, so reads on RA/RB/RD see pending writes.

Parameters:
- DEPTH, 4, number of queued write entries; power of two, at least 2.
- DATA_W, 32, register data width.
- ADDR_W, 5, register number width.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  1  write request present.
- req_ready  out  1  queue can accept a request this cycle.
- req_rd  in  ADDR_W  destination register number.
- req_data  in  DATA_W  value to write.
- wb_hold  in  1  register file write port unavailable this cycle; suppresses issue.
- RW  out  ADDR_W  register file write select.
- PW  out  DATA_W  register file write data.
- LE  out  1  register file write enable.
- RA, RB, RD  in  ADDR_W each  read selects, mirrored from the register file inputs.
- fwd_hit_a, fwd_hit_b, fwd_hit_d  out  1 each  a queued entry matches the corresponding select.
- fwd_data_a, fwd_data_b, fwd_data_d  out  DATA_W each  youngest matching queued value; 0 when no hit.
- empty  out  1  no entries queued.

Behaviour:
- **Interface.** One clock, Clk. Reset is synchronous and active-high, named Reset.
- **Reset.**
  - While Reset=1 at a rising edge: head and tail pointers and the count clear to 0, and all entries are invalidated.
  - Reset mid-operation discards pending writes; none are issued.
  - While Reset is high: req_ready=0 and LE=0.
  - After reset: LE=0, RW=0, PW=0, empty=1, req_ready=1, all fwd_hit=0, all fwd_data=0.
- **State.**
  - count is $clog2(DEPTH)+1 bits wide.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- **Accept.**
  - req_ready = (count < DEPTH) and not Reset. The ready signal does not depend on req_valid.
  - A request is accepted at an edge where req_valid and req_ready are both 1.
  - An accepted request with req_rd=0 is dropped: it is not enqueued and count does not change, because %g0 is hardwired zero.
- **Issue.**
  - Outputs are combinational from the head entry: LE = !empty & !wb_hold, RW = head.rd, PW = head.data.
  - When empty, RW=0 and PW=0.
  - The entry is popped at the same rising edge on which the register file samples LE=1.
  - Latency: a request accepted at edge N into an empty queue with wb_hold=0 drives LE=1 during cycle N+1 and is written at edge N+1.
  - Entries issue strictly in acceptance order, so writes to the same register land in program order.
- **Simultaneous push/pop.**
  - Both may occur at the same edge; count is then unchanged.
  - When full, req_ready=0, so a push cannot coincide with a pop at full. There is no pass-through.
- **wb_hold=1.** No pop and LE=0. Accepts continue until the queue is full.
- **Forwarding.**
  - Purely combinational.
  - For each select S: hit when S!=0 and some valid entry has rd==S. Data comes from the youngest matching entry, i.e. the one nearest the tail.
  - The head entry being issued this cycle still counts as a hit.
  - Requests not yet accepted are never forwarded.

Decomposition:
- Shared package holds:
  - DATA_W and ADDR_W
  - REG_ZERO = 0
  - the write-entry struct (valid, rd, data)
- One sub-module, regfile_fwd_lookup: one select in, DEPTH entries plus the head pointer in, hit and data out. Instantiated three times (A, B, D).

Test Plan:
1. Reset, then one request rd=5, data=0xDEADBEEF, wb_hold=0 -> next cycle LE=1, RW=5, PW=0xDEADBEEF; the following cycle LE=0 and empty=1.
2. wb_hold=1, push rd=1..5 with data 0x11..0x15 -> 4 accepted, req_ready=0 on the 5th. Release hold -> LE pulses 4 cycles with RW=1,2,3,4 in order; req_ready returns to 1 after the first pop.
3. wb_hold=1, push r7=0x1 then r7=0x2, RA=7, RB=3 -> fwd_hit_a=1, fwd_data_a=0x2, fwd_hit_b=0, fwd_data_b=0.
4. Push rd=0, data=0xFFFFFFFF -> req_ready=1, count unchanged, empty stays 1, LE never asserts. RD=0 -> fwd_hit_d=0.
5. Queue 3 entries under hold, assert Reset for one cycle with hold released -> LE stays 0, empty=1 afterwards, no write issued.
6. Steady stream, one push per cycle with hold=0 (rd=8,9,10) -> count stays at 1. Each write issues one cycle after its acceptance, with no bubbles.

Source files
------------

// File: rtl/regfile_writeback_queue_pkg.sv
// Shared widths and the write-entry record used by the register file writeback queue
// and its forwarding lookup.
package regfile_writeback_queue_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_fwd_lookup.sv
// Forwarding lookup for one read select: finds the youngest queued entry writing
// the selected register, scanning from the head (oldest) toward the tail.
module regfile_fwd_lookup
    import regfile_writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0]          sel,
    input  wb_entry_t [DEPTH-1:0]      entries,
    input  logic [PTR_W-1:0]           headPtr,
    output logic                       hit,
    output logic [DATA_W-1:0]          data
);

    logic [PTR_W-1:0] idx;

    // Walking oldest to youngest lets the last match win, which is the entry nearest the tail.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = headPtr + PTR_W'(k);
            if (sel != REG_ZERO && entries[idx].valid && entries[idx].rd == sel) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Writer-side front end for the 32x32 register file: buffers write requests in a small
// FIFO, issues one write per clock and forwards still-queued data to the three read ports.
module regfile_writeback_queue
    import regfile_writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic [DATA_W-1:0] req_data,
    input  logic              wb_hold,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] PW,
    output logic              LE,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [ADDR_W-1:0] RD,
    output logic              fwd_hit_a,
    output logic              fwd_hit_b,
    output logic              fwd_hit_d,
    output logic [DATA_W-1:0] fwd_data_a,
    output logic [DATA_W-1:0] fwd_data_b,
    output logic [DATA_W-1:0] fwd_data_d,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    wb_entry_t [DEPTH-1:0] entries;
    logic [PTR_W-1:0]      headPtr;
    logic [PTR_W-1:0]      tailPtr;
    logic [PTR_W:0]        count;

    logic pushEn;
    logic popEn;

    // Writes to %g0 are acknowledged but never stored, since that register is hardwired zero.
    always_comb begin
        empty     = (count == '0);
        req_ready = (count < FULL_COUNT) && !Reset;
        pushEn    = req_valid && req_ready && (req_rd != REG_ZERO);
        LE        = !empty && !wb_hold && !Reset;
        popEn     = LE;
        RW        = empty ? REG_ZERO : entries[headPtr].rd;
        PW        = empty ? '0 : entries[headPtr].data;
    end

    // A push and a pop never target the same slot: pushes need a non-full queue and pops a non-empty one.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            entries <= '0;
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (pushEn) begin
                entries[tailPtr] <= '{valid: 1'b1, rd: req_rd, data: req_data};
                tailPtr          <= tailPtr + 1'b1;
            end
            if (popEn) begin
                entries[headPtr].valid <= 1'b0;
                headPtr                <= headPtr + 1'b1;
            end
            case ({pushEn, popEn})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    regfile_fwd_lookup #(.DEPTH(DEPTH)) fwdA (
        .sel     (RA),
        .entries (entries),
        .headPtr (headPtr),
        .hit     (fwd_hit_a),
        .data    (fwd_data_a)
    );

    regfile_fwd_lookup #(.DEPTH(DEPTH)) fwdB (
        .sel     (RB),
        .entries (entries),
        .headPtr (headPtr),
        .hit     (fwd_hit_b),
        .data    (fwd_data_b)
    );

    regfile_fwd_lookup #(.DEPTH(DEPTH)) fwdD (
        .sel     (RD),
        .entries (entries),
        .headPtr (headPtr),
        .hit     (fwd_hit_d),
        .data    (fwd_data_d)
    );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench for regfile_writeback_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rd;
    logic [31:0] req_data;
    logic        wb_hold;
    logic [4:0]  RW;
    logic [31:0] PW;
    logic        LE;
    logic [4:0]  RA, RB, RD;
    logic        fwd_hit_a, fwd_hit_b, fwd_hit_d;
    logic [31:0] fwd_data_a, fwd_data_b, fwd_data_d;
    logic        empty;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t modelQ[$];
    int   checks   = 0;
    int   failures = 0;

    regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rd     (req_rd),
        .req_data   (req_data),
        .wb_hold    (wb_hold),
        .RW         (RW),
        .PW         (PW),
        .LE         (LE),
        .RA         (RA),
        .RB         (RB),
        .RD         (RD),
        .fwd_hit_a  (fwd_hit_a),
        .fwd_hit_b  (fwd_hit_b),
        .fwd_hit_d  (fwd_hit_d),
        .fwd_data_a (fwd_data_a),
        .fwd_data_b (fwd_data_b),
        .fwd_data_d (fwd_data_d),
        .empty      (empty)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Youngest queued write to sel wins; register 0 never hits.
    task automatic modelFwd(input logic [4:0] sel, output logic hit, output logic [31:0] data);
        hit  = 1'b0;
        data = '0;
        if (sel != 0) begin
            for (int i = modelQ.size() - 1; i >= 0; i--) begin
                if (modelQ[i].rd == sel) begin
                    hit  = 1'b1;
                    data = modelQ[i].data;
                    break;
                end
            end
        end
    endtask

    function automatic logic modelLe();
        return !Reset && modelQ.size() != 0 && !wb_hold;
    endfunction

    task automatic checkOutput();
        logic        h;
        logic [31:0] d;
        int          sz;
        sz = modelQ.size();
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("req_ready", 32'(req_ready), 32'(!Reset && sz < DEPTH));
        chk("LE", 32'(LE), 32'(modelLe()));
        chk("RW", 32'(RW), sz != 0 ? 32'(modelQ[0].rd) : 32'd0);
        chk("PW", PW, sz != 0 ? modelQ[0].data : 32'd0);
        modelFwd(RA, h, d);
        chk("fwd_hit_a", 32'(fwd_hit_a), 32'(h));
        chk("fwd_data_a", fwd_data_a, d);
        modelFwd(RB, h, d);
        chk("fwd_hit_b", 32'(fwd_hit_b), 32'(h));
        chk("fwd_data_b", fwd_data_b, d);
        modelFwd(RD, h, d);
        chk("fwd_hit_d", 32'(fwd_hit_d), 32'(h));
        chk("fwd_data_d", fwd_data_d, d);
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [31:0] data,
                                 input logic hold, input logic [4:0] a, input logic [4:0] b,
                                 input logic [4:0] dsel, input logic rst);
        req_valid = v;
        req_rd    = rd;
        req_data  = data;
        wb_hold   = hold;
        RA        = a;
        RB        = b;
        RD        = dsel;
        Reset     = rst;
        #1;
        checkOutput();
    endtask

    // Clock one edge and move the model: pop what was issued, then enqueue the accepted request.
    task automatic advance();
        logic canAccept;
        logic doPop;
        canAccept = !Reset && modelQ.size() < DEPTH;
        doPop     = modelLe();
        @(posedge Clk);
        if (Reset) begin
            modelQ.delete();
        end else begin
            if (doPop) void'(modelQ.pop_front());
            if (req_valid && canAccept && req_rd != 0) modelQ.push_back('{rd: req_rd, data: req_data});
        end
        @(negedge Clk);
    endtask

    initial begin
        req_valid = 1'b0;
        req_rd    = '0;
        req_data  = '0;
        wb_hold   = 1'b0;
        RA        = '0;
        RB        = '0;
        RD        = '0;
        Reset     = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);

        // Still in reset: ready and LE must be low.
        applyStimulus(1'b1, 5'd9, 32'h1234, 1'b0, 5'd9, 5'd0, 5'd0, 1'b1);
        chk("reset_ready", 32'(req_ready), 32'd0);
        advance();

        // Scenario 1: single write, one-cycle latency.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("post_reset_empty", 32'(empty), 32'd1);
        chk("post_reset_LE", 32'(LE), 32'd0);
        advance();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0);
        chk("s1_LE", 32'(LE), 32'd1);
        chk("s1_RW", 32'(RW), 32'd5);
        chk("s1_PW", PW, 32'hDEADBEEF);
        chk("s1_head_fwd", 32'(fwd_hit_a), 32'd1);
        advance();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("s1_LE_after", 32'(LE), 32'd0);
        chk("s1_empty_after", 32'(empty), 32'd1);
        advance();

        // Scenario 2: fill under hold, then drain in order.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 5'(i), 32'h10 + 32'(i), 1'b1, 5'd3, 5'(i), 5'd0, 1'b0);
            if (i == 5) chk("s2_full_ready", 32'(req_ready), 32'd0);
            advance();
        end
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd1, 5'd2, 1'b0);
            chk("s2_drain_LE", 32'(LE), 32'd1);
            chk("s2_drain_RW", 32'(RW), 32'(i));
            advance();
            if (i == 1) begin
                #1;
                chk("s2_ready_back", 32'(req_ready), 32'd1);
            end
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("s2_drained", 32'(empty), 32'd1);

        // Scenario 3: youngest of two writes to r7 is forwarded.
        applyStimulus(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 5'd3, 5'd0, 1'b0);
        advance();
        applyStimulus(1'b1, 5'd7, 32'h2, 1'b1, 5'd7, 5'd3, 5'd0, 1'b0);
        advance();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd3, 5'd0, 1'b0);
        chk("s3_hit_a", 32'(fwd_hit_a), 32'd1);
        chk("s3_data_a", fwd_data_a, 32'h2);
        chk("s3_hit_b", 32'(fwd_hit_b), 32'd0);
        chk("s3_data_b", fwd_data_b, 32'h0);
        advance();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0);
            advance();
        end

        // Scenario 4: writes to r0 are swallowed.
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("s4_ready", 32'(req_ready), 32'd1);
        advance();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("s4_empty", 32'(empty), 32'd1);
        chk("s4_LE", 32'(LE), 32'd0);
        chk("s4_hit_d", 32'(fwd_hit_d), 32'd0);
        advance();

        // Scenario 5: reset discards queued writes.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'(20 + i), 32'hA0 + 32'(i), 1'b1, 5'd20, 5'd21, 5'd22, 1'b0);
            advance();
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd20, 5'd21, 5'd22, 1'b1);
        chk("s5_LE_in_reset", 32'(LE), 32'd0);
        advance();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd20, 5'd21, 5'd22, 1'b0);
        chk("s5_empty", 32'(empty), 32'd1);
        chk("s5_LE", 32'(LE), 32'd0);
        chk("s5_hit_a", 32'(fwd_hit_a), 32'd0);
        advance();

        // Scenario 6: back-to-back stream, each write issues the cycle after acceptance.
        for (int i = 0; i < 4; i++) begin
            if (i < 3) applyStimulus(1'b1, 5'(8 + i), 32'hC0 + 32'(i), 1'b0, 5'(8 + i), 5'd0, 5'd0, 1'b0);
            else       applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            if (i > 0) begin
                chk("s6_LE", 32'(LE), 32'd1);
                chk("s6_RW", 32'(RW), 32'(8 + i - 1));
                chk("s6_not_empty", 32'(empty), 32'd0);
            end
            advance();
        end

        // Random traffic against the model, with occasional resets.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          1'($urandom_range(0, 49) == 0));
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
